// File: rtl/uart_irq_pkg.sv
// Shared definitions for the UART interrupt scheduler: register map, CTRL/MASK
// field positions and the interrupt FSM state encoding.
package uart_irq_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_MASK    = 4'd1;
  localparam logic [3:0] ADDR_THRESH  = 4'd2;
  localparam logic [3:0] ADDR_PENDING = 4'd3;
  localparam logic [3:0] ADDR_NEXT    = 4'd4;
  localparam logic [3:0] ADDR_ACK     = 4'd5;
  localparam logic [3:0] ADDR_STATS   = 4'd6;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_HOLD_LSB  = 16;
  localparam int MASK_TX_LSB    = 16;
  localparam int NEXT_VALID_BIT = 31;

  // Channel index width; covers up to 16 channels.
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder: returns the first set request
// at or after ptr, wrapping modulo NCHAN.
module rr_pick #(
  parameter int NCHAN = 8,
  parameter int IDX_W = 4
) (
  input  logic [NCHAN-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NCHAN);

  logic [NCHAN-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so that bit 0 is channel ptr, then take the lowest set bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rot   = NCHAN'({req, req} >> ptr);
    off   = '0;
    valid = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDX_W'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    index = valid ? sum[IDX_W-1:0] : '0;
  end

endmodule

// File: rtl/uart_irq_sched.sv
// Interrupt scheduler for the UART array: pending detection, ack/holdoff irq
// FSM and round-robin NEXT channel. Optional STATS register: UART_IRQ_STATS_EN.
module uart_irq_sched
  import uart_irq_pkg::*;
#(
  parameter int NCHAN  = 8,
  parameter int LVL_W  = 5,
  parameter int HOLD_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic                   cfg_re,
  input  logic [3:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  input  logic [NCHAN*LVL_W-1:0] rx_level,
  input  logic [NCHAN-1:0]       tx_empty,
  output logic                   irq
);

  logic              en;
  logic [HOLD_W-1:0] holdoff;
  logic [NCHAN-1:0]  rxen, txen;
  logic [LVL_W-1:0]  thresh, thr_eff;

  logic [NCHAN-1:0]  rx_pend, tx_pend, req;
  logic              any_pend;
  logic              pick_valid, next_valid;
  logic [IDX_W-1:0]  pick_idx, next_idx, ptr;

  irq_state_t        state, state_d;
  logic [HOLD_W-1:0] cnt, cnt_d;
  logic              irq_d, ack_wr;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata;
  assign ack_wr       = cfg_we && (cfg_addr == ADDR_ACK);

  // A zero threshold behaves as one so an empty FIFO never raises RX pending.
  assign thr_eff = (thresh == '0) ? LVL_W'(1) : thresh;

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      rx_pend[i] = rxen[i] && (rx_level[i*LVL_W +: LVL_W] >= thr_eff);
    end
    tx_pend = txen & tx_empty;
  end

  assign req      = rx_pend | tx_pend;
  assign any_pend = |req;

  rr_pick #(.NCHAN(NCHAN), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      holdoff <= '0;
      rxen    <= '0;
      txen    <= '0;
      thresh  <= '0;
    end else if (cfg_we) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (cfg_addr)
        ADDR_CTRL: begin
          en      <= cfg_wdata[CTRL_EN_BIT];
          holdoff <= cfg_wdata[CTRL_HOLD_LSB +: HOLD_W];
        end
        ADDR_MASK: begin
          rxen <= cfg_wdata[NCHAN-1:0];
          txen <= cfg_wdata[MASK_TX_LSB +: NCHAN];
        end
        ADDR_THRESH: thresh <= cfg_wdata[LVL_W-1:0];
        default: ;
      endcase
    end
  end

  // The pointer moves past the channel the driver just serviced, whatever the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_valid <= 1'b0;
      next_idx   <= '0;
      ptr        <= '0;
    end else begin
      next_valid <= pick_valid;
      next_idx   <= pick_idx;
      if (ack_wr && next_valid) begin
        ptr <= (next_idx == IDX_W'(NCHAN - 1)) ? '0 : next_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (any_pend) state_d = ASSERT;
      end
      ASSERT: begin
        if (ack_wr) begin
          state_d = (holdoff == '0) ? IDLE : HOLD;
          cnt_d   = holdoff;
        end
      end
      HOLD: begin
        if (cnt <= HOLD_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // irq follows the registered state, so it drops on the ACK edge or one cycle after EN clears.
  assign irq_d = (state == ASSERT) && en && !ack_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      irq   <= irq_d;
    end
  end

`ifdef UART_IRQ_STATS_EN
  logic [31:0] stats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stats <= '0;
    end else if (cfg_we && (cfg_addr == ADDR_STATS)) begin
      stats <= '0;
    end else if ((state == IDLE) && (state_d == ASSERT) && (stats != '1)) begin
      stats <= stats + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN_BIT]                = en;
        rd_mux[CTRL_HOLD_LSB +: HOLD_W]    = holdoff;
      end
      ADDR_MASK: begin
        rd_mux[NCHAN-1:0]                  = rxen;
        rd_mux[MASK_TX_LSB +: NCHAN]       = txen;
      end
      ADDR_THRESH:  rd_mux[LVL_W-1:0]      = thresh;
      ADDR_PENDING: begin
        rd_mux[NCHAN-1:0]                  = rx_pend;
        rd_mux[MASK_TX_LSB +: NCHAN]       = tx_pend;
      end
      ADDR_NEXT: begin
        rd_mux[NEXT_VALID_BIT]             = next_valid;
        rd_mux[IDX_W-1:0]                  = next_idx;
      end
`ifdef UART_IRQ_STATS_EN
      ADDR_STATS: rd_mux = stats;
`else
      ADDR_STATS: rd_mux = '0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_rdata <= '0;
    end else if (cfg_re) begin
      cfg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_uart_irq_sched.sv
// Directed bench for uart_irq_sched: register reads go through a scoreboard
// queue checked by a monitor; irq timing is checked inline.
module tb_uart_irq_sched;
  import uart_irq_pkg::*;

  localparam int NCHAN  = 8;
  localparam int LVL_W  = 5;
  localparam int HOLD_W = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cfg_we = 1'b0;
  logic                   cfg_re = 1'b0;
  logic [3:0]             cfg_addr = '0;
  logic [31:0]            cfg_wdata = '0;
  logic [31:0]            cfg_rdata;
  logic [NCHAN*LVL_W-1:0] rx_level = '0;
  logic [NCHAN-1:0]       tx_empty = '0;
  logic                   irq;

  uart_irq_sched #(.NCHAN(NCHAN), .LVL_W(LVL_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .rx_level  (rx_level),
    .tx_empty  (tx_empty),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    cfg_addr = a;
    cfg_re   = 1'b1;
    @(negedge clk);
    cfg_re   = 1'b0;
  endtask

  task automatic set_lvl(input int ch, input logic [LVL_W-1:0] v);
    rx_level[ch*LVL_W +: LVL_W] = v;
  endtask

  // Monitor: a read strobe seen at a rising edge yields cfg_rdata by the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (cfg_re) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got read data %h with no expected entry", cfg_rdata);
        end else begin
          e = sb.pop_front();
          check(e.name, cfg_rdata, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(1);
    check("irq_after_reset", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 7; a++) rd(4'(a), 32'h0, $sformatf("reset_rd%0d", a));

    // Threshold crossing on channel 0.
    set_lvl(0, 5'd3);
    wr(ADDR_THRESH, 32'd4);
    wr(ADDR_MASK, 32'h0000_0001);
    wr(ADDR_CTRL, 32'h0000_0001);
    tick(3);
    check("irq_below_thresh", {31'b0, irq}, 32'h0);
    set_lvl(0, 5'd4);
    tick(1);
    check("irq_lat1", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_lat2", {31'b0, irq}, 32'h1);
    rd(ADDR_PENDING, 32'h0000_0001, "pending_ch0");
    rd(ADDR_NEXT, 32'h8000_0000, "next_ch0");

    // Holdoff of 10; a CTRL write mid-hold must not reload the count.
    wr(ADDR_CTRL, 32'h000A_0001);
    wr(ADDR_ACK, 32'h0);
    check("irq_ack_drop", {31'b0, irq}, 32'h0);
    tick(2);
    wr(ADDR_CTRL, 32'h0000_0001);
    tick(6);
    check("hold_a9", {31'b0, irq}, 32'h0);
    tick(1);
    check("hold_a10", {31'b0, irq}, 32'h0);
    tick(1);
    check("hold_a11", {31'b0, irq}, 32'h0);
    tick(1);
    check("hold_a12", {31'b0, irq}, 32'h1);

    // Holdoff of 0: ACK goes straight back to IDLE.
    wr(ADDR_ACK, 32'h0);
    check("h0_ack", {31'b0, irq}, 32'h0);
    tick(1);
    check("h0_a1", {31'b0, irq}, 32'h0);
    tick(1);
    check("h0_a2", {31'b0, irq}, 32'h1);

    // Round robin over channels 2, 5, 7 (pointer sits at 1 after the ACKs above).
    set_lvl(0, 5'd0);
    set_lvl(2, 5'd4);
    set_lvl(5, 5'd4);
    set_lvl(7, 5'd4);
    wr(ADDR_MASK, 32'h0000_00FF);
    tick(2);
    rd(ADDR_PENDING, 32'h0000_00A4, "pending_257");
    rd(ADDR_NEXT, 32'h8000_0002, "rr_2");
    wr(ADDR_ACK, 32'h0);
    tick(1);
    rd(ADDR_NEXT, 32'h8000_0005, "rr_5");
    wr(ADDR_ACK, 32'h0);
    tick(1);
    rd(ADDR_NEXT, 32'h8000_0007, "rr_7");
    wr(ADDR_ACK, 32'h0);
    tick(1);
    rd(ADDR_NEXT, 32'h8000_0002, "rr_wrap");

    // Threshold 0 acts as 1; then TX-only pending.
    set_lvl(2, 5'd0);
    set_lvl(5, 5'd0);
    set_lvl(7, 5'd0);
    set_lvl(1, 5'd1);
    wr(ADDR_THRESH, 32'd0);
    wr(ADDR_MASK, 32'h0000_0003);
    rd(ADDR_PENDING, 32'h0000_0002, "thresh_zero");
    tx_empty = 8'h08;
    wr(ADDR_MASK, 32'h0008_0000);
    rd(ADDR_PENDING, 32'h0008_0000, "pending_tx3");
    rd(ADDR_MASK, 32'h0008_0000, "mask_readback");
    rd(ADDR_CTRL, 32'h0000_0001, "ctrl_readback");

    // EN clear drops irq next cycle; re-enable raises it 2 cycles later.
    tick(3);
    check("pre_en_clear", {31'b0, irq}, 32'h1);
    wr(ADDR_CTRL, 32'h0);
    tick(1);
    check("en_clear", {31'b0, irq}, 32'h0);
    wr(ADDR_CTRL, 32'h0000_0001);
    check("reen_a0", {31'b0, irq}, 32'h0);
    tick(1);
    check("reen_a1", {31'b0, irq}, 32'h0);
    tick(1);
    check("reen_a2", {31'b0, irq}, 32'h1);

    // Reset in the middle of a 20-cycle hold.
    wr(ADDR_CTRL, 32'h0014_0001);
    wr(ADDR_ACK, 32'h0);
    tick(2);
    check("hold_pre_reset", {31'b0, irq}, 32'h0);
    reset = 1'b1;
    #1;
    check("reset_mid_hold", {31'b0, irq}, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    rd(ADDR_CTRL, 32'h0, "ctrl_after_reset");
    rd(ADDR_MASK, 32'h0, "mask_after_reset");
    rd(ADDR_NEXT, 32'h0, "next_after_reset");

    // Three IDLE->ASSERT transitions, then STATS read/clear.
    wr(ADDR_MASK, 32'h0008_0000);
    wr(ADDR_CTRL, 32'h0000_0001);
    tick(3);
    check("st_irq1", {31'b0, irq}, 32'h1);
    wr(ADDR_ACK, 32'h0);
    tick(3);
    check("st_irq2", {31'b0, irq}, 32'h1);
    wr(ADDR_ACK, 32'h0);
    tick(3);
    check("st_irq3", {31'b0, irq}, 32'h1);
`ifdef UART_IRQ_STATS_EN
    rd(ADDR_STATS, 32'd3, "stats_three");
    wr(ADDR_STATS, 32'h0);
    rd(ADDR_STATS, 32'd0, "stats_cleared");
`else
    rd(ADDR_STATS, 32'd0, "stats_unmapped");
    wr(ADDR_STATS, 32'hFFFF_FFFF);
    rd(ADDR_STATS, 32'd0, "stats_unmapped_wr");
`endif

    // Asynchronous reset while irq is high.
    reset = 1'b1;
    #1;
    check("async_reset_irq", {31'b0, irq}, 32'h0);
    tick(1);
    reset = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: got %0d outstanding reads expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_irq_sched.md
Name: uart_irq_sched

Overview:
- Interrupt scheduler for the 8-channel UART array behind the PS AXI slave.
- Computes per-channel RX/TX pending from FIFO status. Drives the single `axi_irq` line with ack-based handshake and programmable holdoff (coalescing).
- Publishes a round-robin "next channel to service" so the driver drains channels fairly.
- Configured through a small word-addressed register port decoded by the AXI slave logic.

Parameters:
- NCHAN, 8, number of UART channels (1..16).
- LVL_W, 5, width of each RX FIFO level field.
- HOLD_W, 16, width of the holdoff counter.

Ports:
- clk  in  1  design clock (host_clk domain).
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  register write strobe.
- cfg_re  in  1  register read strobe.
- cfg_addr  in  4  word index.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, registered.
- rx_level  in  NCHAN*LVL_W  RX FIFO fill level per channel; channel i at [i*LVL_W +: LVL_W].
- tx_empty  in  NCHAN  TX FIFO empty per channel.
- irq  out  1  interrupt to PS, level-high.

Behaviour:
- Register map, by cfg_addr:
  - 0 CTRL: bit0 EN; [31:16] HOLDOFF cycles.
  - 1 MASK: [NCHAN-1:0] RX enable; [NCHAN+15:16] TX enable.
  - 2 RX_THRESH: [LVL_W-1:0].
  - 3 PENDING (RO): RX pending at [NCHAN-1:0], TX pending at [NCHAN+15:16].
  - 4 NEXT (RO): bit31 valid; [3:0] channel index.
  - 5 ACK (WO): any write acknowledges.
  - Writes to RO or unmapped addresses are ignored. Unmapped reads return 0.
- Reset values: all registers 0, irq=0, cfg_rdata=0, RR pointer=0, state IDLE.
- Read timing: cfg_rdata is updated the cycle after cfg_re and holds its value otherwise. Reads have no side effects.
- Pending logic (combinational from inputs and registers):
  - rx_pend[i] = RXEN[i] && rx_level[i] >= max(RX_THRESH, 1).
  - tx_pend[i] = TXEN[i] && tx_empty[i].
  - any_pend = OR of both vectors.
- NEXT, registered every cycle: first channel c = ptr, ptr+1, … (mod NCHAN) with rx_pend[c] | tx_pend[c]. If none, valid=0 and index=0.
- RR pointer: on ACK write with NEXT.valid=1, ptr <= NEXT.index+1 (mod NCHAN). Otherwise unchanged.
- FSM states: IDLE, ASSERT, HOLD.
  - IDLE: irq=0. EN && any_pend → ASSERT next cycle.
  - ASSERT: irq=1. Stays asserted even if pending clears (latched). ACK write → HOLD with cnt <= HOLDOFF. If HOLDOFF==0, ACK goes directly to IDLE.
  - HOLD: irq=0. cnt decrements each cycle; cnt==1 → IDLE. Pending events during HOLD are not lost; they are re-evaluated in IDLE.
  - EN=0 in any state → IDLE next cycle, irq=0, cnt cleared.
- Simultaneous events:
  - ACK and new pending in the same cycle: ACK wins (go to HOLD).
  - CTRL write during HOLD: the running count is not reloaded; the new HOLDOFF applies from the next ACK.
  - ACK in IDLE or HOLD: FSM ignores it; the RR pointer still advances if NEXT is valid.
- Reset mid-operation: immediate return to reset values, irq deasserts asynchronously.
- Latency: pending input change → irq high in 2 cycles (1 for IDLE → ASSERT registration, irq registered).

Optional Feature:
- Macro UART_IRQ_STATS_EN.
- Defined: address 6 STATS (RO) holds a 32-bit count of IDLE→ASSERT transitions, saturating at 0xFFFFFFFF. Any write to address 6 clears it. Reset value 0.
- Undefined: address 6 is unmapped (reads 0, writes ignored); no counter logic is generated.

Decomposition:
- Package uart_irq_pkg:
  - Register address localparams (ADDR_CTRL..ADDR_STATS).
  - FSM state enum (IDLE/ASSERT/HOLD, 2-bit).
  - CTRL field bit positions.
- Sub-module rr_pick: parameterised NCHAN round-robin first-set finder.
  - Inputs: req vector, ptr.
  - Outputs: valid, index.
  - Purely combinational.
  - Reused by later DMA arbitration work.

Test Plan:
- Reset, then read addresses 0–5 → all read 0. irq=0 after deasserting reset.
- EN=1, RXEN=0x01, RX_THRESH=4, rx_level[0]=3→4 → irq high 2 cycles after level reaches 4; PENDING=0x1; NEXT=0x80000000.
- HOLDOFF=10 with ch0 held pending, write ACK → irq low for 10 cycles, then high again 2 cycles later. HOLDOFF=0 → re-asserts 2 cycles after ACK.
- RXEN=0xFF, channels 2, 5, 7 pending, ACK three times → NEXT reports 2, 5, 7, then wraps to 2.
- While irq=1, clear EN → irq=0 next cycle. Re-enable → irq high 2 cycles later. Assert reset mid-HOLD → irq=0 and state IDLE immediately.
- With UART_IRQ_STATS_EN defined, produce 3 irq assertions → address 6 reads 3; write address 6 → reads 0. Without the macro, address 6 reads 0.
